// File: rtl/fsm_seq_gen_if.sv
// Command channel between the control logic and the symbol sequencer.
// The requester drives a target tracker state; the sequencer answers with ready.
interface fsm_seq_gen_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_target;

    modport master (output cmd_valid, output cmd_target, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_target, output cmd_ready);
endinterface

// File: rtl/fsm_seq_gen.sv
// Drives the 2-bit symbol input of the 5-state tracker, steering a shadow copy of it
// to a commanded state by the shortest route and reporting done/err/symbol count.
module fsm_seq_gen #(
    parameter int S1_TIMEOUT = 3,
    parameter int S2_DWELL   = 2,
    parameter int S3_TIMEOUT = 3
) (
    input  logic             clk,
    input  logic             clr,
    fsm_seq_gen_if.slave     cmd,
    output logic [1:0]       sym,
    output logic [2:0]       shadow_state,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       cycles
);
    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;

    localparam int CW = 8;
    localparam logic [CW-1:0] T1 = CW'(S1_TIMEOUT);
    localparam logic [CW-1:0] T2 = CW'(S2_DWELL);
    localparam logic [CW-1:0] T3 = CW'(S3_TIMEOUT);

    logic [2:0]    st, st_n, tgt;
    logic [CW-1:0] c1, c2, c3, c1_n, c2_n, c3_n;
    logic [7:0]    cnt, cnt_inc;

    assign shadow_state  = st;
    assign cmd.cmd_ready = ~busy;
    assign cnt_inc       = (cnt == 8'hff) ? 8'hff : cnt + 8'd1;

    // Shadow of the tracker: same rule, fed with the symbol we are driving now.
    always_comb begin
        st_n = st;
        c1_n = c1;
        c2_n = c2;
        c3_n = c3;
        case (st)
            S0: if (sym == 2'd0) begin st_n = S1; c1_n = CW'(1); end
            S1: begin
                if (sym == 2'd2) begin
                    st_n = S2; c1_n = '0; c2_n = CW'(1);
                end else if (sym == 2'd3) begin
                    st_n = S4; c1_n = '0;
                end else if (c1 == T1) begin
                    st_n = S0; c1_n = '0;
                end else begin
                    c1_n = c1 + CW'(1);
                end
            end
            S2: begin
                if (c2 == T2) begin
                    st_n = S3; c2_n = '0; c3_n = CW'(1);
                end else begin
                    c2_n = c2 + CW'(1);
                end
            end
            S3: begin
                if (sym == 2'd1) begin
                    st_n = S1; c1_n = CW'(1); c3_n = '0;
                end else if (c3 == T3) begin
                    st_n = S0; c3_n = '0;
                end else begin
                    c3_n = c3 + CW'(1);
                end
            end
            S4: ;
            default: begin
                st_n = S0; c1_n = '0; c2_n = '0; c3_n = '0;
            end
        endcase
    end

    // Idle fill keeps the tracker parked; busy uses the next-hop table.
    always_comb begin
        sym = (st == S0 || st == S1) ? 2'd1 : 2'd0;
        if (busy) begin
            case (tgt)
                S0: case (st)
                        S1:     sym = 2'd1;
                        S2, S3: sym = 2'd0;
                        default: ;
                    endcase
                S1: case (st)
                        S0, S2: sym = 2'd0;
                        S3:     sym = 2'd1;
                        default: ;
                    endcase
                S2: case (st)
                        S0: sym = 2'd0;
                        S1: sym = 2'd2;
                        S3: sym = 2'd1;
                        default: ;
                    endcase
                S3: case (st)
                        S0, S2: sym = 2'd0;
                        S1:     sym = 2'd2;
                        default: ;
                    endcase
                S4: case (st)
                        S0, S2: sym = 2'd0;
                        S1:     sym = 2'd3;
                        S3:     sym = 2'd1;
                        default: ;
                    endcase
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            st     <= S0;
            c1     <= '0;
            c2     <= '0;
            c3     <= '0;
            tgt    <= S0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            cnt    <= '0;
            cycles <= '0;
        end else begin
            st   <= st_n;
            c1   <= c1_n;
            c2   <= c2_n;
            c3   <= c3_n;
            done <= 1'b0;
            err  <= 1'b0;
            if (busy) begin
                cnt <= cnt_inc;
                if (st_n == tgt) begin
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    cycles <= cnt_inc;
                end
            end else if (cmd.cmd_valid) begin
                // S4 only releases on clr, so any other target from there is unreachable.
                if (cmd.cmd_target > S4 || (st == S4 && cmd.cmd_target != S4)) begin
                    err <= 1'b1;
                end else if (cmd.cmd_target == st) begin
                    done   <= 1'b1;
                    cycles <= '0;
                end else begin
                    tgt  <= cmd.cmd_target;
                    busy <= 1'b1;
                    cnt  <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fsm_seq_gen.sv
// Directed bench for fsm_seq_gen: each step pushes the expected post-edge outputs,
// which are popped and compared after the edge.
module tb_fsm_seq_gen;
    logic       clk = 1'b0;
    logic       clr;
    logic [1:0] sym;
    logic [2:0] shadow_state;
    logic       busy, done, err;
    logic [7:0] cycles;

    fsm_seq_gen_if cif();

    fsm_seq_gen dut (
        .clk          (clk),
        .clr          (clr),
        .cmd          (cif),
        .sym          (sym),
        .shadow_state (shadow_state),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .cycles       (cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [1:0] sym;
        logic [2:0] st;
        logic       busy;
        logic       done;
        logic       err;
        logic       ready;
        logic [7:0] cyc;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic compare_all(input exp_t e);
        chk({e.tag, ".sym"},   {6'd0, sym},            {6'd0, e.sym});
        chk({e.tag, ".state"}, {5'd0, shadow_state},   {5'd0, e.st});
        chk({e.tag, ".busy"},  {7'd0, busy},           {7'd0, e.busy});
        chk({e.tag, ".done"},  {7'd0, done},           {7'd0, e.done});
        chk({e.tag, ".err"},   {7'd0, err},            {7'd0, e.err});
        chk({e.tag, ".ready"}, {7'd0, cif.cmd_ready},  {7'd0, e.ready});
        chk({e.tag, ".cycles"}, cycles,                e.cyc);
    endtask

    function automatic exp_t mk(input string tag, input logic [1:0] s, input logic [2:0] st,
                                input logic b, input logic d, input logic e, input logic [7:0] c);
        exp_t x;
        x.tag = tag; x.sym = s; x.st = st; x.busy = b; x.done = d; x.err = e;
        x.ready = ~b; x.cyc = c;
        return x;
    endfunction

    // Called at a negedge: drive command, expect outputs after the next rising edge.
    task automatic step(input string tag, input logic v, input logic [2:0] t,
                        input logic [1:0] s, input logic [2:0] st,
                        input logic b, input logic d, input logic e, input logic [7:0] c);
        exp_t x;
        cif.cmd_valid  = v;
        cif.cmd_target = t;
        q.push_back(mk(tag, s, st, b, d, e, c));
        @(posedge clk);
        @(negedge clk);
        cif.cmd_valid  = 1'b0;
        cif.cmd_target = 3'd0;
        x = q.pop_front();
        compare_all(x);
    endtask

    initial begin
        clr = 1'b1;
        cif.cmd_valid  = 1'b0;
        cif.cmd_target = 3'd0;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        compare_all(mk("rst", 2'd1, 3'd0, 0, 0, 0, 8'd0));

        // target 3 from reset: sym 0,2,0,0
        step("t3.acc",  1, 3'd3, 2'd0, 3'd0, 1, 0, 0, 8'd0);
        step("t3.s1",   0, 3'd0, 2'd2, 3'd1, 1, 0, 0, 8'd0);
        step("t3.s2",   0, 3'd0, 2'd0, 3'd2, 1, 0, 0, 8'd0);
        step("t3.s2b",  0, 3'd0, 2'd0, 3'd2, 1, 0, 0, 8'd0);
        step("t3.done", 0, 3'd0, 2'd0, 3'd3, 0, 1, 0, 8'd4);

        // idle in S3 with cnt3=1: fill 0,0,0 then times out to S0
        step("idle1", 0, 3'd0, 2'd0, 3'd3, 0, 0, 0, 8'd4);
        step("idle2", 0, 3'd0, 2'd0, 3'd3, 0, 0, 0, 8'd4);
        step("idle3", 0, 3'd0, 2'd1, 3'd0, 0, 0, 0, 8'd4);

        // target 1, then back-to-back target 0 in the done cycle
        step("t1.acc",  1, 3'd1, 2'd0, 3'd0, 1, 0, 0, 8'd4);
        step("t1.done", 0, 3'd0, 2'd1, 3'd1, 0, 1, 0, 8'd1);
        step("t0.acc",  1, 3'd0, 2'd1, 3'd1, 1, 0, 0, 8'd1);
        step("t0.s1",   0, 3'd0, 2'd1, 3'd1, 1, 0, 0, 8'd1);
        step("t0.done", 0, 3'd0, 2'd1, 3'd0, 0, 1, 0, 8'd2);

        // target equal to current state, then illegal target
        step("eq.done",   1, 3'd0, 2'd1, 3'd0, 0, 1, 0, 8'd0);
        step("bad.err",   1, 3'd5, 2'd1, 3'd0, 0, 0, 1, 8'd0);
        step("bad.after", 0, 3'd0, 2'd1, 3'd0, 0, 0, 0, 8'd0);

        // back to S3, then target 4 via S1
        step("r3.acc",  1, 3'd3, 2'd0, 3'd0, 1, 0, 0, 8'd0);
        step("r3.s1",   0, 3'd0, 2'd2, 3'd1, 1, 0, 0, 8'd0);
        step("r3.s2",   0, 3'd0, 2'd0, 3'd2, 1, 0, 0, 8'd0);
        step("r3.s2b",  0, 3'd0, 2'd0, 3'd2, 1, 0, 0, 8'd0);
        step("r3.done", 0, 3'd0, 2'd0, 3'd3, 0, 1, 0, 8'd4);
        step("t4.acc",  1, 3'd4, 2'd1, 3'd3, 1, 0, 0, 8'd4);
        step("t4.s1",   0, 3'd0, 2'd3, 3'd1, 1, 0, 0, 8'd4);
        step("t4.done", 0, 3'd0, 2'd0, 3'd4, 0, 1, 0, 8'd2);
        step("s4.rej",  1, 3'd1, 2'd0, 3'd4, 0, 0, 1, 8'd2);
        step("s4.eq",   1, 3'd4, 2'd0, 3'd4, 0, 1, 0, 8'd0);
        step("s4.hold", 0, 3'd0, 2'd0, 3'd4, 0, 0, 0, 8'd0);

        // clr leaves S4; then abort a target-3 command after two symbols
        clr = 1'b1;
        #1;
        compare_all(mk("s4.clr", 2'd1, 3'd0, 0, 0, 0, 8'd0));
        @(negedge clk);
        clr = 1'b0;
        step("ab.acc", 1, 3'd3, 2'd0, 3'd0, 1, 0, 0, 8'd0);
        step("ab.s1",  0, 3'd0, 2'd2, 3'd1, 1, 0, 0, 8'd0);
        step("ab.s2",  0, 3'd0, 2'd0, 3'd2, 1, 0, 0, 8'd0);
        clr = 1'b1;
        #1;
        compare_all(mk("ab.clr", 2'd1, 3'd0, 0, 0, 0, 8'd0));
        @(negedge clk);
        clr = 1'b0;
        step("ab.post1", 0, 3'd0, 2'd1, 3'd0, 0, 0, 0, 8'd0);
        step("ab.post2", 0, 3'd0, 2'd1, 3'd0, 0, 0, 0, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
